// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch controller:
//            FSM state encoding, PC increment and prefetch queue entry format.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low two bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Synchronous FIFO of {pc, inst} entries with flush. Flush wins
//            over push/pop. Head is presented from registers (no bypass) and
//            reads as zero when the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(QUEUE_DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == CNT_W'(QUEUE_DEPTH));
  // A pop frees the head slot this edge, so a full queue may still accept a push.
  assign w_pop   = pop_i & ~w_empty & ~flush_i;
  assign w_push  = push_i & ~flush_i & (~w_full | w_pop);

  // Storage array; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = w_empty ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Instruction fetch controller. Owns the fetch PC, reads the
//            combinational instruction memory, buffers {pc, inst} pairs in a
//            prefetch queue and hands them to decode over valid/ready.
//            Supports halt and redirect (flush + restart).
// Options  : FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_flush_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [31:0]                  mem_addr,
  output logic                         mem_rd_en,
  input  logic [31:0]                  mem_rdata,
  input  logic                         halt,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         inst_valid,
  output logic [31:0]                  inst,
  output logic [31:0]                  inst_pc,
  input  logic                         inst_ready,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_fetch_cnt,
  output logic [31:0]                  perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  fetch_pc_q;

  fetch_entry_t w_push_entry;
  fetch_entry_t w_head;
  logic         w_pop;
  logic         w_full;
  logic         w_flush;

  assign w_pop   = inst_valid & inst_ready;
  assign w_full  = (queue_count == CNT_W'(QUEUE_DEPTH));
  // Redirect is meaningless before the first fetch, so S_RESET ignores it.
  assign w_flush = redirect_valid & (state_q != S_RESET);

  assign mem_addr  = fetch_pc_q;
  assign mem_rd_en = (state_q == S_FETCH) & ~halt & ~redirect_valid & (~w_full | w_pop);

  assign w_push_entry.pc   = fetch_pc_q;
  assign w_push_entry.inst = mem_rdata;

  fetch_queue #(
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (mem_rd_en),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .flush_i     (w_flush),
    .head_o      (w_head),
    .count_o     (queue_count)
  );

  assign inst_valid = (queue_count != '0);
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Next-state: leave reset unconditionally, then follow the halt level.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: state_d = halt ? S_HALT : S_FETCH;
      S_HALT:  state_d = halt ? S_HALT : S_FETCH;
      default: state_d = S_RESET;
    endcase
  end

  // Fetch PC: redirect reloads it, each fetched word advances it, otherwise frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
    end else if (w_flush) begin
      fetch_pc_q <= align_pc(redirect_pc);
    end else if (mem_rd_en) begin
      fetch_pc_q <= fetch_pc_q + PC_STEP;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_flush_q;

  // Count fetched words and discarded entries; a head popped alongside the
  // redirect was consumed by decode and is not counted as discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (mem_rd_en) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (w_flush)   perf_flush_q <= perf_flush_q + 32'(queue_count) - 32'(w_pop);
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Self-checking bench for imem_fetch_ctrl. Stimulus pushes the
//            PCs decode must see into a scoreboard queue; a monitor pops and
//            compares on every accepted handshake. Memory returns pc^DEADBEEF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

  localparam logic [31:0] INST_KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  queue_count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  imem_fetch_ctrl #(
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_rdata      (mem_rdata),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .queue_count    (queue_count)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ INST_KEY;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every accepted head must match the next scoreboard entry.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_accept: got pc %h expected no transfer", inst_pc);
      end else begin
        e = exp_q.pop_front();
        check32("head_pc", inst_pc, e);
        check32("head_inst", inst, e ^ INST_KEY);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    tick(2);
    check32("rst_valid", 32'(inst_valid), 32'h0);
    check32("rst_inst", inst, 32'h0);
    check32("rst_pc", inst_pc, 32'h0);
    check32("rst_rd_en", 32'(mem_rd_en), 32'h0);
    check32("rst_count", 32'(queue_count), 32'h0);
    check32("rst_addr", mem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check32("rst_perf_fetch", perf_fetch_cnt, 32'h0);
`endif

    // Fill with decode stalled: exactly four pushes, then fetch stops at 16.
    reset = 1'b0;
    tick(1);
    check32("first_rd_en", 32'(mem_rd_en), 32'h1);
    check32("first_addr", mem_addr, 32'h0);
    tick(4);
    check32("full_count", 32'(queue_count), 32'h4);
    check32("full_rd_en", 32'(mem_rd_en), 32'h0);
    check32("full_addr", mem_addr, 32'h10);
`ifdef FETCH_PERF_CNT_EN
    check32("perf_fetch4", perf_fetch_cnt, 32'h4);
`endif
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    inst_ready = 1'b1;
    tick(4);
    inst_ready = 1'b0;
    #1;
    check32("stream_count", 32'(queue_count), 32'h4);
    check32("stream_addr", mem_addr, 32'h20);

    // Redirect on a full queue: flush, align to 0x100.
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    #1;
    check32("redir_rd_en", 32'(mem_rd_en), 32'h0);
    tick(1);
    redirect_valid = 1'b0;
    #1;
    check32("redir_count", 32'(queue_count), 32'h0);
    check32("redir_addr", mem_addr, 32'h100);
    check32("redir_rd_en2", 32'(mem_rd_en), 32'h1);
`ifdef FETCH_PERF_CNT_EN
    check32("perf_flush4", perf_flush_cnt, 32'h4);
`endif
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    inst_ready = 1'b1;
    tick(4);
    inst_ready = 1'b0;

    // Halt with two queued: they drain, PC stays frozen, fetch resumes there.
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick(1);
    redirect_valid = 1'b0;
    tick(2);
    halt = 1'b1;
    #1;
    check32("halt_count", 32'(queue_count), 32'h2);
    check32("halt_rd_en", 32'(mem_rd_en), 32'h0);
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    inst_ready = 1'b1;
    tick(3);
    check32("halt_drained", 32'(queue_count), 32'h0);
    check32("halt_addr", mem_addr, 32'h208);
    halt = 1'b0; inst_ready = 1'b0;
    tick(3);
    check32("resume_count", 32'(queue_count), 32'h2);
    exp_q.push_back(32'h208); exp_q.push_back(32'h20C);
    inst_ready = 1'b1;
    tick(2);
    inst_ready = 1'b0;

    // PC wraps from the top of the address space to zero.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect_valid = 1'b0;
    #1;
    check32("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    tick(2);
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    inst_ready = 1'b1;
    tick(2);
    inst_ready = 1'b0;

    // Reset mid-stream with three queued clears outputs immediately.
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick(1);
    redirect_valid = 1'b0;
    tick(3);
    check32("mid_count", 32'(queue_count), 32'h3);
    reset = 1'b1;
    #1;
    check32("mid_rst_valid", 32'(inst_valid), 32'h0);
    check32("mid_rst_count", 32'(queue_count), 32'h0);
    check32("mid_rst_pc", inst_pc, 32'h0);
    check32("mid_rst_addr", mem_addr, 32'h0);
    check32("mid_rst_rd_en", 32'(mem_rd_en), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check32("mid_rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check32("mid_rst_perf_flush", perf_flush_cnt, 32'h0);
`endif
    tick(2);
    reset = 1'b0;
    tick(3);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    inst_ready = 1'b1;
    tick(2);
    inst_ready = 1'b0;
    tick(2);

    check32("scoreboard_left", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
